// File: rtl/object_plotter.sv
// object_plotter: erases an object's old rectangle in background colour, then
// draws its new rectangle in the object colour, one pixel per clock, driving
// the VGA adapter's pixel-write port.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   startPlot            request strobe, sampled only while idle
//   object[1:0]          00 ball, 01 paddle, 10 block (erase only), 11 none
//   newX/oldX[7:0]       top-left column of new/old rectangle
//   newY/oldY[6:0]       top-left row of new/old rectangle
//   sizeX[7:0]/sizeY[6:0] rectangle width/height in pixels
//   x[7:0], y[6:0]       pixel coordinate (truncated sum)
//   colour[2:0], plot    pixel colour and write enable
//   busy, done, overrun  request in progress / end pulse / sticky drop flag
module object_plotter #(
  parameter logic [7:0] MAX_X         = 8'd159,
  parameter logic [6:0] MAX_Y         = 7'd119,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter logic [2:0] BALL_COLOUR   = 3'b111,
  parameter logic [2:0] PADDLE_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       startPlot,
  input  logic [1:0] object,
  input  logic [7:0] newX,
  input  logic [7:0] oldX,
  input  logic [6:0] newY,
  input  logic [6:0] oldY,
  input  logic [7:0] sizeX,
  input  logic [6:0] sizeY,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;

  localparam logic [1:0] OBJ_PADDLE = 2'b01;
  localparam logic [1:0] OBJ_BLOCK  = 2'b10;
  localparam logic [1:0] OBJ_NONE   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_d;

  // Captured request; upstream muxes move on after the capture edge.
  logic [1:0]     r_object;
  logic [XW-1:0]  r_new_x;
  logic [XW-1:0]  r_old_x;
  logic [YW-1:0]  r_new_y;
  logic [YW-1:0]  r_old_y;
  logic [XW-1:0]  r_size_x;
  logic [YW-1:0]  r_size_y;

  // Scan counters hold the coordinate of the pixel currently presented.
  logic [XW-1:0]  r_cx;
  logic [YW-1:0]  r_cy;
  logic [XW-1:0]  w_cx_d;
  logic [YW-1:0]  w_cy_d;

  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [2:0]     r_colour;
  logic           r_plot;
  logic           r_busy;
  logic           r_done;
  logic           r_overrun;

  logic           w_capture;
  logic           w_pix_valid;
  logic [XW-1:0]  w_base_x;
  logic [YW-1:0]  w_base_y;
  logic [2:0]     w_pix_colour;
  logic [2:0]     w_obj_colour;
  logic           w_last_col;
  logic           w_last_pix;
  logic [XW:0]    w_sum_x;
  logic [YW:0]    w_sum_y;
  logic           w_plot_d;

  assign w_obj_colour = (r_object == OBJ_PADDLE) ? PADDLE_COLOUR : BALL_COLOUR;
  assign w_last_col   = (r_cx == (r_size_x - XW'(1)));
  assign w_last_pix   = w_last_col && (r_cy == (r_size_y - YW'(1)));

  // Next state, next scan position and the pixel to present after this edge.
  always_comb begin
    w_state_d    = r_state;
    w_cx_d       = r_cx;
    w_cy_d       = r_cy;
    w_capture    = 1'b0;
    w_pix_valid  = 1'b0;
    w_base_x     = r_old_x;
    w_base_y     = r_old_y;
    w_pix_colour = BG_COLOUR;

    case (r_state)
      S_IDLE: begin
        if (startPlot && (object != OBJ_NONE)) begin
          w_capture = 1'b1;
          w_cx_d    = '0;
          w_cy_d    = '0;
          if ((sizeX == '0) || (sizeY == '0)) begin
            w_state_d = S_DONE;
          end else begin
            w_state_d   = S_ERASE;
            w_pix_valid = 1'b1;
            w_base_x    = oldX;
            w_base_y    = oldY;
          end
        end
      end

      S_ERASE: begin
        if (w_last_pix) begin
          w_cx_d = '0;
          w_cy_d = '0;
          if (r_object == OBJ_BLOCK) begin
            w_state_d = S_DONE;
          end else begin
            w_state_d    = S_DRAW;
            w_pix_valid  = 1'b1;
            w_base_x     = r_new_x;
            w_base_y     = r_new_y;
            w_pix_colour = w_obj_colour;
          end
        end else begin
          w_pix_valid = 1'b1;
          if (w_last_col) begin
            w_cx_d = '0;
            w_cy_d = r_cy + YW'(1);
          end else begin
            w_cx_d = r_cx + XW'(1);
          end
        end
      end

      S_DRAW: begin
        w_base_x     = r_new_x;
        w_base_y     = r_new_y;
        w_pix_colour = w_obj_colour;
        if (w_last_pix) begin
          w_state_d = S_DONE;
          w_cx_d    = '0;
          w_cy_d    = '0;
        end else begin
          w_pix_valid = 1'b1;
          if (w_last_col) begin
            w_cx_d = '0;
            w_cy_d = r_cy + YW'(1);
          end else begin
            w_cx_d = r_cx + XW'(1);
          end
        end
      end

      S_DONE: begin
        w_state_d = S_IDLE;
      end

      default: begin
        w_state_d = S_IDLE;
      end
    endcase
  end

  // Sums are one bit wider so off-screen pixels are suppressed, not wrapped.
  assign w_sum_x  = {1'b0, w_base_x} + {1'b0, w_cx_d};
  assign w_sum_y  = {1'b0, w_base_y} + {1'b0, w_cy_d};
  assign w_plot_d = w_pix_valid && (w_sum_x <= {1'b0, MAX_X}) &&
                    (w_sum_y <= {1'b0, MAX_Y});

  // State, counters and capture registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cx     <= '0;
      r_cy     <= '0;
      r_object <= '0;
      r_new_x  <= '0;
      r_old_x  <= '0;
      r_new_y  <= '0;
      r_old_y  <= '0;
      r_size_x <= '0;
      r_size_y <= '0;
    end else begin
      r_state <= w_state_d;
      r_cx    <= w_cx_d;
      r_cy    <= w_cy_d;
      if (w_capture) begin
        r_object <= object;
        r_new_x  <= newX;
        r_old_x  <= oldX;
        r_new_y  <= newY;
        r_old_y  <= oldY;
        r_size_x <= sizeX;
        r_size_y <= sizeY;
      end
    end
  end

  // Registered pixel port and status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x       <= '0;
      r_y       <= '0;
      r_colour  <= '0;
      r_plot    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_pix_valid) begin
        r_x      <= w_sum_x[XW-1:0];
        r_y      <= w_sum_y[YW-1:0];
        r_colour <= w_pix_colour;
      end
      r_plot    <= w_plot_d;
      r_busy    <= (w_state_d != S_IDLE);
      r_done    <= (w_state_d == S_DONE);
      r_overrun <= r_overrun | (startPlot & r_busy);
    end
  end

  assign x       = r_x;
  assign y       = r_y;
  assign colour  = r_colour;
  assign plot    = r_plot;
  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_object_plotter.sv
module tb_object_plotter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       startPlot;
  logic [1:0] object;
  logic [7:0] newX, oldX, sizeX;
  logic [6:0] newY, oldY, sizeY;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done, overrun;

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  pix_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  object_plotter dut (
    .clk(clk), .resetn(resetn), .startPlot(startPlot), .object(object),
    .newX(newX), .oldX(oldX), .newY(newY), .oldY(oldY),
    .sizeX(sizeX), .sizeY(sizeY),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: expected visible writes of one rectangle scan.
  task automatic push_rect(input int bx, input int by, input int w, input int h,
                           input logic [2:0] c);
    for (int cy = 0; cy < h; cy++) begin
      for (int cx = 0; cx < w; cx++) begin
        int sx;
        int sy;
        pix_t p;
        sx = bx + cx;
        sy = by + cy;
        if (sx <= 159 && sy <= 119) begin
          p.px = 8'(sx);
          p.py = 7'(sy);
          p.pc = c;
          sb_q.push_back(p);
        end
      end
    end
  endtask

  // Scoreboard consumer: every plot pulse must match the next expected write.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (resetn && plot) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write x=%0d y=%0d colour=%0d", x, y, colour);
        end else begin
          pix_t e;
          e = sb_q.pop_front();
          if ({x, y, colour} !== {e.px, e.py, e.pc}) begin
            errors++;
            $display("FAIL sb_pixel got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                     x, y, colour, e.px, e.py, e.pc);
          end
        end
      end
    end
  endtask

  // Present one request at the capture edge E0, then scramble the inputs.
  task automatic start_req(input logic [1:0] obj, input int ox, input int oy,
                           input int nx, input int ny, input int sx, input int sy);
    @(negedge clk);
    object = obj; oldX = 8'(ox); oldY = 7'(oy); newX = 8'(nx); newY = 7'(ny);
    sizeX = 8'(sx); sizeY = 7'(sy); startPlot = 1'b1;
    @(posedge clk);
    #1;
    startPlot = 1'b0; object = 2'b11;
    oldX = 8'($urandom); oldY = 7'($urandom); newX = 8'($urandom);
    newY = 7'($urandom); sizeX = 8'($urandom); sizeY = 7'($urandom);
  endtask

  // Observe cycles E0+1.. until idle after done (bounded); optional late strobe.
  task automatic run_req(input int max_cyc, input int poke_at, output int done_at,
                         output int busy_cnt, output int plot_cnt, output int done_cnt);
    done_at = -1; busy_cnt = 0; plot_cnt = 0; done_cnt = 0;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      if (poke_at != 0 && n == poke_at) begin
        startPlot = 1'b1; object = 2'b01; newX = 8'd3; newY = 7'd3;
        oldX = 8'd7; oldY = 7'd7; sizeX = 8'd2; sizeY = 7'd2;
      end else begin
        startPlot = 1'b0;
      end
      if (busy) busy_cnt++;
      if (plot) plot_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (!busy && done_at > 0) break;
    end
    startPlot = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({x, y, colour, plot, busy, done, overrun} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {x, y, colour, plot, busy, done, overrun});
    end
  endtask

  task automatic test_ball();
    int d, b, p, dc;
    push_rect(50, 100, 4, 4, 3'b000);
    push_rect(51, 99, 4, 4, 3'b111);
    start_req(2'b00, 50, 100, 51, 99, 4, 4);
    run_req(60, 0, d, b, p, dc);
    checks++; if (d !== 33) begin errors++; $display("FAIL ball_done_cycle got %0d want 33", d); end
    checks++; if (b !== 33) begin errors++; $display("FAIL ball_busy_cycles got %0d want 33", b); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL ball_done_pulses got %0d want 1", dc); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL ball_missing_writes got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_paddle_edge();
    int d, b, p, dc;
    push_rect(100, 50, 20, 1, 3'b000);
    push_rect(145, 117, 20, 1, 3'b010);
    start_req(2'b01, 100, 50, 145, 117, 20, 1);
    run_req(80, 0, d, b, p, dc);
    checks++; if (b !== 41) begin errors++; $display("FAIL paddle_busy_cycles got %0d want 41", b); end
    checks++; if (p !== 35) begin errors++; $display("FAIL paddle_plot_pulses got %0d want 35", p); end
    checks++; if (d !== 41) begin errors++; $display("FAIL paddle_done_cycle got %0d want 41", d); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL paddle_missing_writes got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_block();
    int d, b, p, dc;
    push_rect(32, 10, 16, 10, 3'b000);
    start_req(2'b10, 32, 10, 0, 0, 16, 10);
    run_req(300, 0, d, b, p, dc);
    checks++; if (d !== 161) begin errors++; $display("FAIL block_done_cycle got %0d want 161", d); end
    checks++; if (p !== 160) begin errors++; $display("FAIL block_plot_pulses got %0d want 160", p); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL block_missing_writes got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_zero_and_none();
    int d, b, p, dc;
    start_req(2'b00, 10, 10, 20, 20, 0, 4);
    run_req(10, 0, d, b, p, dc);
    checks++; if (d !== 1) begin errors++; $display("FAIL zero_done_cycle got %0d want 1", d); end
    checks++; if (p !== 0) begin errors++; $display("FAIL zero_plot_pulses got %0d want 0", p); end
    checks++; if (b !== 1) begin errors++; $display("FAIL zero_busy_cycles got %0d want 1", b); end
    start_req(2'b11, 10, 10, 20, 20, 4, 4);
    run_req(6, 0, d, b, p, dc);
    checks++; if (b !== 0) begin errors++; $display("FAIL none_busy_cycles got %0d want 0", b); end
    checks++; if (dc !== 0) begin errors++; $display("FAIL none_done_pulses got %0d want 0", dc); end
  endtask

  task automatic test_overrun();
    int d, b, p, dc;
    push_rect(20, 30, 4, 4, 3'b000);
    push_rect(22, 31, 4, 4, 3'b111);
    start_req(2'b00, 20, 30, 22, 31, 4, 4);
    run_req(60, 5, d, b, p, dc);
    checks++; if (d !== 33) begin errors++; $display("FAIL overrun_done_cycle got %0d want 33", d); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %0b want 1", overrun); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL overrun_missing_writes got %0d want 0", sb_q.size()); end
    // Back-to-back: a request right after the first idle edge is accepted.
    push_rect(51, 99, 4, 4, 3'b000);
    push_rect(52, 100, 4, 4, 3'b111);
    start_req(2'b00, 51, 99, 52, 100, 4, 4);
    run_req(60, 0, d, b, p, dc);
    checks++; if (d !== 33) begin errors++; $display("FAIL b2b_done_cycle got %0d want 33", d); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %0b want 1", overrun); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL b2b_missing_writes got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid();
    int d, b, p, dc;
    int seen_done;
    push_rect(10, 20, 8, 3, 3'b000);
    push_rect(12, 22, 8, 3, 3'b010);
    start_req(2'b01, 10, 20, 12, 22, 8, 3);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if ({x, y, colour, plot, busy, done, overrun} !== 22'd0) begin
      errors++;
      $display("FAIL midreset_outputs got %h want 0", {x, y, colour, plot, busy, done, overrun});
    end
    sb_q.delete();
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || plot) seen_done++;
    end
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done || busy || plot) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL midreset_activity got %0d want 0", seen_done); end
    push_rect(0, 0, 4, 4, 3'b000);
    push_rect(1, 1, 4, 4, 3'b111);
    start_req(2'b00, 0, 0, 1, 1, 4, 4);
    run_req(60, 0, d, b, p, dc);
    checks++; if (d !== 33) begin errors++; $display("FAIL post_reset_done_cycle got %0d want 33", d); end
    checks++; if (p !== 32) begin errors++; $display("FAIL post_reset_plots got %0d want 32", p); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL post_reset_missing got %0d want 0", sb_q.size()); end
  endtask

  initial begin
    resetn = 1'b0; startPlot = 1'b0; object = 2'b11;
    newX = '0; oldX = '0; newY = '0; oldY = '0; sizeX = '0; sizeY = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    @(negedge clk);
    test_ball();
    test_paddle_edge();
    test_block();
    test_zero_and_none();
    test_overrun();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
